// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared state encoding and 250 kbaud 8N1 link timing for adc_scan_sequencer.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    PUBLISH,
    GAP
  } seq_state_t;

  localparam logic [7:0] CMD_BASE_DEFAULT = 8'hA1;

  // One 8N1 frame is 10 bit times; a reply byte may take up to ~5 frames to arrive.
  localparam int CLK_HZ           = 12_000_000;
  localparam int BAUD             = 250_000;
  localparam int CLKS_PER_BIT     = CLK_HZ / BAUD;
  localparam int CLKS_PER_BYTE    = 10 * CLKS_PER_BIT;
  localparam int TIMEOUT_DEFAULT  = 5 * CLKS_PER_BYTE;
  localparam int SCAN_GAP_DEFAULT = CLK_HZ / 1000;

  localparam int TIMER_W = 16;

endpackage

// File: rtl/adc_seq_timer.sv
// adc_seq_timer: loadable down-counter; tc is high while the count sits at zero.
module adc_seq_timer
  import adc_seq_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk12MHz,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk12MHz or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin ADC command/reply scheduler over the UART link.
// Define ADC_SEQ_RETRY_EN to retry a channel once after its first reply timeout.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int         NUM_CH   = 4,
  parameter logic [7:0] CMD_BASE = CMD_BASE_DEFAULT,
  parameter int         SCAN_GAP = SCAN_GAP_DEFAULT,
  parameter int         TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic              clk12MHz,
  input  logic              resetn,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [15:0]       sample,
  output logic [1:0]        sample_ch,
  output logic              sample_valid,
  output logic              timeout_err,
  output logic              busy
);

  localparam logic [TIMER_W-1:0] REPLY_LOAD = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(SCAN_GAP - 1);

  seq_state_t         state, state_n;
  logic [1:0]         ch, ptr, next_ch, ptr_after;
  logic [7:0]         hi_byte;
  logic               sel_ch, latch_hi, latch_lo, timeout_n;
  logic               tmr_load, tmr_tc;
  logic [TIMER_W-1:0] tmr_value;
`ifdef ADC_SEQ_RETRY_EN
  logic               retried, set_retry, clr_retry;
`endif

  // First enabled channel at or after start, wrapping; ptr always holds (last + 1).
  function automatic logic [1:0] next_channel(input logic [1:0] start,
                                              input logic [NUM_CH-1:0] mask);
    logic [1:0] sel;
    logic       found;
    int         idx;
    sel   = start;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(start) + i) % NUM_CH;
      if (!found && mask[idx[1:0]]) begin
        sel   = idx[1:0];
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign next_ch   = next_channel(ptr, ch_mask);
  assign ptr_after = (next_ch == 2'(NUM_CH - 1)) ? 2'd0 : next_ch + 2'd1;

  always_ff @(posedge clk12MHz or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    sel_ch    = 1'b0;
    latch_hi  = 1'b0;
    latch_lo  = 1'b0;
    timeout_n = 1'b0;
    tmr_load  = 1'b0;
    tmr_value = '0;
`ifdef ADC_SEQ_RETRY_EN
    set_retry = 1'b0;
    clr_retry = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enable && (|ch_mask)) begin
          state_n = SEND;
          sel_ch  = 1'b1;
        end
      end
      SEND: begin
        if (tx_ready) begin
          state_n   = WAIT_HI;
          tmr_load  = 1'b1;
          tmr_value = REPLY_LOAD;
        end
      end
      // A byte arriving on the terminal-count cycle takes priority over the timeout.
      WAIT_HI, WAIT_LO: begin
        if (rx_valid) begin
          if (state == WAIT_HI) begin
            latch_hi  = 1'b1;
            state_n   = WAIT_LO;
            tmr_load  = 1'b1;
            tmr_value = REPLY_LOAD;
          end else begin
            latch_lo = 1'b1;
            state_n  = PUBLISH;
          end
        end else if (tmr_tc) begin
`ifdef ADC_SEQ_RETRY_EN
          if (!retried) begin
            state_n   = SEND;
            set_retry = 1'b1;
          end else begin
            state_n   = GAP;
            tmr_load  = 1'b1;
            tmr_value = GAP_LOAD;
            timeout_n = 1'b1;
            clr_retry = 1'b1;
          end
`else
          state_n   = GAP;
          tmr_load  = 1'b1;
          tmr_value = GAP_LOAD;
          timeout_n = 1'b1;
`endif
        end
      end
      PUBLISH: begin
        state_n   = GAP;
        tmr_load  = 1'b1;
        tmr_value = GAP_LOAD;
`ifdef ADC_SEQ_RETRY_EN
        clr_retry = 1'b1;
`endif
      end
      GAP: begin
        if (!enable || tmr_tc) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk12MHz or negedge resetn) begin
    if (!resetn) begin
      ch          <= 2'd0;
      ptr         <= 2'd0;
      hi_byte     <= 8'h00;
      sample      <= 16'h0000;
      sample_ch   <= 2'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_n;
      if (sel_ch) begin
        ch  <= next_ch;
        ptr <= ptr_after;
      end
      if (latch_hi) begin
        hi_byte <= rx_data;
      end
      if (latch_lo) begin
        sample    <= {hi_byte, rx_data};
        sample_ch <= ch;
      end
    end
  end

`ifdef ADC_SEQ_RETRY_EN
  always_ff @(posedge clk12MHz or negedge resetn) begin
    if (!resetn) begin
      retried <= 1'b0;
    end else if (clr_retry || sel_ch) begin
      retried <= 1'b0;
    end else if (set_retry) begin
      retried <= 1'b1;
    end
  end
`endif

  adc_seq_timer #(.W(TIMER_W)) u_timer (
    .clk12MHz   (clk12MHz),
    .resetn     (resetn),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tc         (tmr_tc)
  );

  // tx_data is derived from ch, which only moves in IDLE, so it is stable throughout SEND.
  assign tx_valid     = (state == SEND);
  assign tx_data      = tx_valid ? (CMD_BASE + {6'd0, ch}) : 8'h00;
  assign sample_valid = (state == PUBLISH);
  assign busy         = (state != IDLE) && (state != GAP);

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: directed checks of command order, reply capture, gap, timeouts and reset.
`timescale 1ns/1ps
module tb_adc_scan_sequencer;

  logic        clk12MHz = 1'b0;
  logic        resetn;
  logic        enable;
  logic [3:0]  ch_mask;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] sample;
  logic [1:0]  sample_ch;
  logic        sample_valid;
  logic        timeout_err;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;
  int svPulses    = 0;

  logic [7:0] rrCmd [4] = '{8'hA1, 8'hA2, 8'hA4, 8'hA1};
  int         rrCh  [4] = '{0, 1, 3, 0};

  adc_scan_sequencer dut (
    .clk12MHz     (clk12MHz),
    .resetn       (resetn),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .sample       (sample),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #42 clk12MHz = ~clk12MHz;

  always @(posedge clk12MHz) begin
    if (sample_valid) svPulses++;
  end

  task automatic tick();
    @(negedge clk12MHz);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] mask);
    enable  = en;
    ch_mask = mask;
    tick();
  endtask

  // Dropping enable for two cycles cuts the GAP short and lands in IDLE.
  task automatic skipGap(input logic [3:0] mask);
    applyStimulus(1'b0, mask);
    applyStimulus(1'b0, mask);
    enable = 1'b1;
  endtask

  task automatic waitTx(input int budget, output int waited);
    waited = 0;
    while (!tx_valid && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  task automatic waitTimeout(input int budget, output int waited);
    waited = 0;
    while (!timeout_err && !tx_valid && waited < budget) begin
      tick();
      waited++;
    end
  endtask

  task automatic handshake(input string tag, input logic [7:0] expCmd);
    int w;
    waitTx(20000, w);
    checkOutput({tag, "_txvalid"}, {31'd0, tx_valid}, 32'd1);
    checkOutput({tag, "_cmd"}, {24'd0, tx_data}, {24'd0, expCmd});
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    checkOutput({tag, "_txdrop"}, {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic sendReply(input logic [7:0] hi, input logic [7:0] lo);
    rx_data  = hi;
    rx_valid = 1'b1;
    tick();
    rx_data  = lo;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  initial begin
    #(100000 * 84);
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int bad;
    int seen;
    int sv0;
    resetn   = 1'b0;
    enable   = 1'b0;
    ch_mask  = 4'b0000;
    tx_ready = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) tick();
    checkOutput("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_sample", {16'd0, sample}, 32'd0);
    checkOutput("rst_sample_ch", {30'd0, sample_ch}, 32'd0);
    checkOutput("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
    checkOutput("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    resetn = 1'b1;
    applyStimulus(1'b0, 4'b1011);
    enable = 1'b1;

    for (int k = 0; k < 4; k++) begin
      handshake($sformatf("rr%0d", k), rrCmd[k]);
      sendReply(8'(rrCh[k]), rrCmd[k]);
      checkOutput($sformatf("rr%0d_sv", k), {31'd0, sample_valid}, 32'd1);
      checkOutput($sformatf("rr%0d_ch", k), {30'd0, sample_ch}, 32'(rrCh[k]));
      checkOutput($sformatf("rr%0d_sample", k), {16'd0, sample}, {16'd0, 8'(rrCh[k]), rrCmd[k]});
      skipGap((k == 3) ? 4'b0001 : 4'b1011);
    end

    handshake("single", 8'hA1);
    sendReply(8'h02, 8'h7F);
    checkOutput("single_sv", {31'd0, sample_valid}, 32'd1);
    checkOutput("single_sample", {16'd0, sample}, 32'h027F);
    checkOutput("single_ch", {30'd0, sample_ch}, 32'd0);
    tick();
    checkOutput("sv_strobe", {31'd0, sample_valid}, 32'd0);
    checkOutput("gap_busy", {31'd0, busy}, 32'd0);
    waitTx(13000, w);
    checkOutput("gap_len", w, 32'd12001);

    bad = 0;
    for (int i = 0; i < 500; i++) begin
      if (!(tx_valid === 1'b1 && tx_data === 8'hA1)) bad++;
      tick();
    end
    checkOutput("stall_stable", bad, 32'd0);
    checkOutput("stall_busy", {31'd0, busy}, 32'd1);
    handshake("repeat", 8'hA1);

    enable = 1'b0;
    repeat (3) tick();
    checkOutput("noen_busy", {31'd0, busy}, 32'd1);
    sendReply(8'h12, 8'h34);
    checkOutput("noen_sv", {31'd0, sample_valid}, 32'd1);
    checkOutput("noen_sample", {16'd0, sample}, 32'h1234);
    ch_mask = 4'b0011;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_valid) seen++;
    end
    checkOutput("noen_tx", seen, 32'd0);
    checkOutput("noen_idle", {31'd0, busy}, 32'd0);

    sv0 = svPulses;
    enable = 1'b1;
    handshake("to", 8'hA2);
`ifdef ADC_SEQ_RETRY_EN
    waitTimeout(3000, w);
    checkOutput("to_retry_wait", w, 32'd2400);
    checkOutput("to_retry_noerr", {31'd0, timeout_err}, 32'd0);
    handshake("to_retry", 8'hA2);
`endif
    waitTimeout(3000, w);
    checkOutput("to_wait", w, 32'd2400);
    checkOutput("to_err", {31'd0, timeout_err}, 32'd1);
    checkOutput("to_sample_hold", {16'd0, sample}, 32'h1234);
    applyStimulus(1'b0, 4'b0011);
    checkOutput("to_strobe", {31'd0, timeout_err}, 32'd0);
    applyStimulus(1'b0, 4'b0011);
    enable = 1'b1;
    checkOutput("to_nosv", svPulses - sv0, 32'd0);
    handshake("to_next", 8'hA1);

    rx_data  = 8'h55;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    waitTimeout(3000, w);
`ifdef ADC_SEQ_RETRY_EN
    checkOutput("hi_retry_wait", w, 32'd2400);
    checkOutput("hi_retry_noerr", {31'd0, timeout_err}, 32'd0);
    handshake("hi_retry", 8'hA1);
    waitTimeout(3000, w);
`endif
    checkOutput("hi_wait", w, 32'd2400);
    checkOutput("hi_to_err", {31'd0, timeout_err}, 32'd1);
    checkOutput("hi_nosv", svPulses - sv0, 32'd0);
    checkOutput("hi_sample_hold", {16'd0, sample}, 32'h1234);

    skipGap(4'b1111);
    handshake("rst_pre", 8'hA2);
    rx_data  = 8'h66;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    checkOutput("pre_rst_busy", {31'd0, busy}, 32'd1);
    #5 resetn = 1'b0;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
    checkOutput("arst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("arst_sample", {16'd0, sample}, 32'd0);
    checkOutput("arst_sample_ch", {30'd0, sample_ch}, 32'd0);
    checkOutput("arst_sample_valid", {31'd0, sample_valid}, 32'd0);
    checkOutput("arst_timeout_err", {31'd0, timeout_err}, 32'd0);
    tick();
    resetn = 1'b1;
    handshake("post_rst", 8'hA1);
    sendReply(8'h0A, 8'hBC);
    checkOutput("post_rst_sv", {31'd0, sample_valid}, 32'd1);
    checkOutput("post_rst_sample", {16'd0, sample}, 32'h0ABC);
    checkOutput("post_rst_ch", {30'd0, sample_ch}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
